dmem_arbiter: RTL and testbench

//  Shares the processor's single-port data memory between two requesters:
//  the core load/store unit (port c_*) and a program/data loader (port l_*).

---
 rtl/dmem_arbiter.sv | 129 ++++++++++++
 tb/tb_dmem_arbiter.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Arbitrates one single-port data memory between the core LSU (c_*) and the loader (l_*).
// One command in flight at a time; read data returns a fixed MEM_LAT cycles after mem_en.
//
// state | meaning
// IDLE  | sample requests, pick a winner, present its command on mem_* next cycle
// ISSUE | mem_en and winner gnt high for one cycle; writes finish here
// WAIT  | count down read latency, capture mem_rdata on the last cycle
// RESP  | winner rvalid high for one cycle
module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              c_req,
  input  logic              c_we,
  input  logic [ADDR_W-1:0] c_addr,
  input  logic [DATA_W-1:0] c_wdata,
  output logic              c_gnt,
  output logic              c_rvalid,
  output logic [DATA_W-1:0] c_rdata,
  input  logic              l_req,
  input  logic              l_we,
  input  logic [ADDR_W-1:0] l_addr,
  input  logic [DATA_W-1:0] l_wdata,
  output logic              l_gnt,
  output logic              l_rvalid,
  output logic [DATA_W-1:0] l_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic       ID_CORE  = 1'b0;
  localparam logic       ID_LDR   = 1'b1;
  localparam logic [2:0] CNT_INIT = 3'(MEM_LAT - 1);

  state_t     state;
  logic       lat_id;
  logic       lat_we;
  logic       last_gnt;
  logic [2:0] cnt;
  logic       pick_l;

  // Loader wins when alone, or on a round-robin tie when the core was served last.
  always_comb begin
    pick_l = l_req && (!c_req || (FIXED_PRIO == 0 && last_gnt == ID_CORE));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      lat_id    <= ID_CORE;
      lat_we    <= 1'b0;
      last_gnt  <= ID_LDR;
      cnt       <= '0;
      c_gnt     <= 1'b0;
      l_gnt     <= 1'b0;
      c_rvalid  <= 1'b0;
      l_rvalid  <= 1'b0;
      c_rdata   <= '0;
      l_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      c_gnt    <= 1'b0;
      l_gnt    <= 1'b0;
      c_rvalid <= 1'b0;
      l_rvalid <= 1'b0;
      mem_en   <= 1'b0;
      case (state)
        IDLE: begin
          if (c_req || l_req) begin
            lat_id    <= pick_l;
            last_gnt  <= pick_l;
            lat_we    <= pick_l ? l_we : c_we;
            mem_en    <= 1'b1;
            mem_we    <= pick_l ? l_we : c_we;
            mem_addr  <= pick_l ? l_addr : c_addr;
            mem_wdata <= pick_l ? l_wdata : c_wdata;
            c_gnt     <= !pick_l;
            l_gnt     <= pick_l;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (lat_we) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt   <= CNT_INIT;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == 3'd0) begin
            if (lat_id == ID_LDR) l_rdata <= mem_rdata;
            else                  c_rdata <= mem_rdata;
            c_rvalid <= (lat_id == ID_CORE);
            l_rvalid <= (lat_id == ID_LDR);
            state    <= RESP;
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench: instance A (MEM_LAT=1, round-robin) and instance B (MEM_LAT=3, fixed priority)
// share all request inputs; each has its own memory model that drives data only in the valid cycle.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        c_req = 1'b0, c_we = 1'b0, l_req = 1'b0, l_we = 1'b0;
  logic [31:0] c_addr = '0, c_wdata = '0, l_addr = '0, l_wdata = '0;

  logic        a_c_gnt, a_c_rvalid, a_l_gnt, a_l_rvalid, a_mem_en, a_mem_we, a_busy;
  logic [31:0] a_c_rdata, a_l_rdata, a_mem_addr, a_mem_wdata;
  logic [31:0] a_mem_rdata = '0;
  logic        b_c_gnt, b_c_rvalid, b_l_gnt, b_l_rvalid, b_mem_en, b_mem_we, b_busy;
  logic [31:0] b_c_rdata, b_l_rdata, b_mem_addr, b_mem_wdata;
  logic [31:0] b_mem_rdata = '0;

  logic [31:0] a_rd_val = '0, b_rd_val = '0;
  logic [3:0]  b_hist = '0;
  logic [15:0] cyc = '0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic        saw;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .FIXED_PRIO(0)) u_a (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(a_c_gnt), .c_rvalid(a_c_rvalid), .c_rdata(a_c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(a_l_gnt), .l_rvalid(a_l_rvalid), .l_rdata(a_l_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(a_mem_rdata), .busy(a_busy)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .FIXED_PRIO(1)) u_b (
    .clk(clk), .reset(reset),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(b_c_gnt), .c_rvalid(b_c_rvalid), .c_rdata(b_c_rdata),
    .l_req(l_req), .l_we(l_we), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(b_l_gnt), .l_rvalid(b_l_rvalid), .l_rdata(b_l_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(b_mem_rdata), .busy(b_busy)
  );

  // Memory models: read data is valid only in the cycle MEM_LAT after mem_en, junk otherwise.
  always @(posedge clk) begin
    cyc    <= cyc + 16'd1;
    b_hist <= {b_hist[2:0], b_mem_en & ~b_mem_we};
    a_mem_rdata <= (a_mem_en & ~a_mem_we) ? a_rd_val : {16'hBAD0, cyc};
    b_mem_rdata <= b_hist[1] ? b_rd_val : {16'hBAD1, cyc};
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outs(input string tag);
    chk({tag, "_a_ctl"}, {25'd0, a_c_gnt, a_l_gnt, a_c_rvalid, a_l_rvalid, a_mem_en, a_mem_we, a_busy}, 32'd0);
    chk({tag, "_b_ctl"}, {25'd0, b_c_gnt, b_l_gnt, b_c_rvalid, b_l_rvalid, b_mem_en, b_mem_we, b_busy}, 32'd0);
  endtask

  initial begin
    // 1: reset with random inputs
    for (int i = 0; i < 4; i++) begin
      step();
      c_req = 1'($urandom); c_we = 1'($urandom); c_addr = $urandom; c_wdata = $urandom;
      l_req = 1'($urandom); l_we = 1'($urandom); l_addr = $urandom; l_wdata = $urandom;
    end
    chk_idle_outs("rst");
    chk("rst_a_rdata", a_c_rdata | a_l_rdata, 32'd0);
    chk("rst_b_rdata", b_c_rdata | b_l_rdata, 32'd0);
    chk("rst_a_mem", a_mem_addr | a_mem_wdata, 32'd0);
    chk("rst_b_mem", b_mem_addr | b_mem_wdata, 32'd0);
    c_req = 0; l_req = 0; c_we = 0; l_we = 0; c_addr = 0; l_addr = 0; c_wdata = 0; l_wdata = 0;
    step();
    reset = 1'b1;

    // 4: both requesting writes continuously; A alternates starting with core, B always core
    step();
    c_req = 1; c_we = 1; c_addr = 32'h100; c_wdata = 32'hC0;
    l_req = 1; l_we = 1; l_addr = 32'h200; l_wdata = 32'h10;
    for (int k = 1; k <= 7; k++) begin
      step();
      if (k % 2 == 1) begin
        chk($sformatf("rr_a_gnt_c%0d", k), {30'd0, a_c_gnt, a_l_gnt}, (k % 4 == 1) ? 32'd2 : 32'd1);
        chk($sformatf("fp_b_gnt_c%0d", k), {30'd0, b_c_gnt, b_l_gnt}, 32'd2);
        chk($sformatf("rr_a_addr_c%0d", k), a_mem_addr, (k % 4 == 1) ? 32'h100 : 32'h200);
      end else begin
        chk($sformatf("rr_a_idle_c%0d", k), {30'd0, a_mem_en, a_busy}, 32'd0);
      end
    end
    c_req = 0; l_req = 0;
    step();

    // 2: core write
    step();
    c_req = 1; c_we = 1; c_addr = 32'h10; c_wdata = 32'hDEADBEEF;
    step();
    chk("wr_a_en_we", {30'd0, a_mem_en, a_mem_we}, 32'd3);
    chk("wr_a_addr", a_mem_addr, 32'h10);
    chk("wr_a_wdata", a_mem_wdata, 32'hDEADBEEF);
    chk("wr_a_gnt", {30'd0, a_c_gnt, a_l_gnt}, 32'd2);
    c_req = 0;
    step();
    chk("wr_a_busy_c2", {30'd0, a_busy, a_mem_en}, 32'd0);
    chk("wr_a_addr_hold", a_mem_addr, 32'h10);

    // 3: loader read of 0x20
    a_rd_val = 32'h12345678; b_rd_val = 32'hB0B00020;
    step();
    l_req = 1; l_we = 0; l_addr = 32'h20;
    step();
    chk("rd_a_issue", {28'd0, a_mem_en, a_mem_we, a_c_gnt, a_l_gnt}, 32'b1001);
    l_req = 0;
    step();
    chk("rd_a_wait", {29'd0, a_busy, a_l_rvalid, a_c_rvalid}, 32'b100);
    step();
    chk("rd_a_resp", {30'd0, a_l_rvalid, a_c_rvalid}, 32'b10);
    chk("rd_a_ldata", a_l_rdata, 32'h12345678);
    step();
    chk("rd_a_done", {30'd0, a_l_rvalid, a_busy}, 32'd0);
    chk("rd_a_ldata_hold", a_l_rdata, 32'h12345678);
    step();
    chk("rd_b_resp", {30'd0, b_l_rvalid, b_c_rvalid}, 32'b10);
    chk("rd_b_ldata", b_l_rdata, 32'hB0B00020);
    step();

    // 5: B core read with MEM_LAT=3, loader request raised during the read
    b_rd_val = 32'hCAFEF00D; a_rd_val = 32'h0A0A0A0A;
    step();
    c_req = 1; c_we = 0; c_addr = 32'h30;
    step();
    chk("l3_b_issue", {29'd0, b_mem_en, b_c_gnt, b_l_gnt}, 32'b110);
    c_req = 0;
    step();
    l_req = 1; l_we = 1; l_addr = 32'h40; l_wdata = 32'h55;
    step();
    step();
    chk("l3_b_rv_c4", {30'd0, b_c_rvalid, b_busy}, 32'b01);
    step();
    chk("l3_b_rv_c5", {29'd0, b_c_rvalid, b_l_gnt, b_mem_en}, 32'b100);
    chk("l3_b_cdata", b_c_rdata, 32'hCAFEF00D);
    chk("l3_b_ldata_indep", b_l_rdata, 32'hB0B00020);
    step();
    chk("l3_b_c6", {29'd0, b_busy, b_l_gnt, b_mem_en}, 32'd0);
    step();
    chk("l3_b_lissue_c7", {28'd0, b_mem_en, b_mem_we, b_c_gnt, b_l_gnt}, 32'b1101);
    chk("l3_b_laddr", b_mem_addr, 32'h40);
    l_req = 0;
    step(); step(); step();

    // 6: reset during WAIT aborts the read
    a_rd_val = 32'h11111111; b_rd_val = 32'h22222222;
    step();
    c_req = 1; c_we = 0; c_addr = 32'h50;
    step();
    chk("ab_gnt", {30'd0, a_c_gnt, b_c_gnt}, 32'b11);
    c_req = 0;
    step();
    chk("ab_wait_busy", {30'd0, a_busy, b_busy}, 32'b11);
    reset = 1'b0;
    #1;
    chk_idle_outs("ab_rst");
    step();
    reset = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (a_c_rvalid | a_l_rvalid | b_c_rvalid | b_l_rvalid | a_c_gnt | b_c_gnt) saw = 1'b1;
    end
    chk("ab_no_rvalid", {31'd0, saw}, 32'd0);
    chk("ab_a_cdata", a_c_rdata, 32'd0);
    chk("ab_b_cdata", b_c_rdata, 32'd0);

    a_rd_val = 32'h600DF00D; b_rd_val = 32'h76543210;
    step();
    c_req = 1; c_we = 0; c_addr = 32'h60;
    step();
    chk("rr2_gnt", {29'd0, a_c_gnt, b_c_gnt, a_mem_en}, 32'b111);
    chk("rr2_a_addr", a_mem_addr, 32'h60);
    c_req = 0;
    step();
    chk("rr2_a_c2", {31'd0, a_c_rvalid}, 32'd0);
    step();
    chk("rr2_a_c3", {31'd0, a_c_rvalid}, 32'd1);
    chk("rr2_a_data", a_c_rdata, 32'h600DF00D);
    step();
    chk("rr2_c4", {30'd0, a_c_rvalid, b_c_rvalid}, 32'd0);
    step();
    chk("rr2_b_c5", {30'd0, b_c_rvalid, b_l_rvalid}, 32'b10);
    chk("rr2_b_data", b_c_rdata, 32'h76543210);
    step();
    chk("rr2_b_c6", {30'd0, b_busy, b_c_rvalid}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
